// File: rtl/mpc_sram_pkg.sv
// Shared types for the cache data-array controller: op codes, FSM states, default sizes.
// No logic here; latency and backpressure live in the modules that import it.
package mpc_sram_pkg;

  localparam int MPC_DATA_W     = 128;
  localparam int MPC_LINE_BEATS = 2;
  localparam int MPC_ADDR_W     = 7;
  localparam int MPC_CH_W       = 2;
  localparam int MPC_ROB_W      = 3;
  localparam int MPC_WBID_W     = 8;

  typedef enum logic [2:0] {
    OP_WR    = 3'b000,
    OP_RD    = 3'b001,
    OP_LF_RD = 3'b010,
    OP_EVICT = 3'b011
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LF,
    S_RD_RTN,
    S_WB_REQ,
    S_WB_RTN,
    S_EV_RD,
    S_EV_SEND
  } state_e;

endpackage

// File: rtl/mpc_sram_sp.sv
// Single-port beat array with byte write enables; read data is registered (1-cycle latency).
// No backpressure: one access per cycle, rdata holds until the next read.
module mpc_sram_sp #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // The storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (cs_i && we_i) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (cs_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mpc_sram_ctrl.sv
// Cache data-array controller: linefill, read, byte-masked write and dirty-beat eviction, one command at a time.
// Read data appears 1 cycle after issue; every output valid holds with stable payload until its enable.
module mpc_sram_ctrl
  import mpc_sram_pkg::*;
#(
  parameter int DATA_W     = MPC_DATA_W,
  parameter int LINE_BEATS = MPC_LINE_BEATS,
  parameter int ADDR_W     = MPC_ADDR_W,
  parameter int CH_W       = MPC_CH_W,
  parameter int ROB_W      = MPC_ROB_W,
  parameter int WBID_W     = MPC_WBID_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mpc_isu_rc_valid,
  output logic                         mpc_isu_rc_enable,
  input  logic [2:0]                   mpc_isu_rc_op_code,
  input  logic [ADDR_W-1:0]            mpc_isu_rc_set_way_offset,
  input  logic [CH_W-1:0]              mpc_isu_rc_channel_id,
  input  logic [ROB_W-1:0]             mpc_isu_rc_xbar_rob_num,
  input  logic [WBID_W-1:0]            mpc_isu_rc_wbuffer_id,
  input  logic [LINE_BEATS-1:0]        mpc_isu_rc_dirty,
  input  logic [LINE_BEATS*DATA_W-1:0] mpc_isu_rc_linefill_data,
  output logic                         mpc_rc_xbar_valid,
  input  logic                         mpc_rc_xbar_enable,
  output logic [CH_W-1:0]              mpc_rc_xbar_channel_id,
  output logic [ROB_W-1:0]             mpc_rc_xbar_rob_num,
  output logic [DATA_W-1:0]            mpc_rc_xbar_data,
  output logic                         mpc_rc_subm_valid,
  input  logic                         mpc_rc_subm_enable,
  output logic [DATA_W-1:0]            mpc_rc_subm_data,
  output logic [ADDR_W-1:0]            mpc_rc_subm_set_way_offset,
  output logic                         mpc_rc_subm_last,
  output logic                         mpc_rc_wbuf_req_valid,
  input  logic                         mpc_rc_wbuf_req_enable,
  output logic [CH_W-1:0]              mpc_rc_wbuf_req_channel_id,
  output logic [WBID_W-1:0]            mpc_rc_wbuf_req_wbuffer_id,
  input  logic                         mpc_rc_wbuf_rtn_valid,
  output logic                         mpc_rc_wbuf_rtn_enable,
  input  logic [DATA_W-1:0]            mpc_rc_wbuf_rtn_data,
  input  logic [DATA_W/8-1:0]          mpc_rc_wbuf_rtn_be
);

  localparam int OFF_W  = $clog2(LINE_BEATS);
  localparam int CNT_W  = OFF_W + 1;
  localparam int BE_W   = DATA_W / 8;
  localparam int BASE_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_BEATS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINE_BEATS-1:0]   dirty_q, dirty_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [ROB_W-1:0]        rob_q, rob_d;
  logic [WBID_W-1:0]       wbid_q, wbid_d;
  logic                    xbar_vld_q, xbar_vld_d;
  logic [DATA_W-1:0]       xbar_dat_q, xbar_dat_d;

  logic                    ram_cs, ram_we;
  logic [BE_W-1:0]         ram_be;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_wdata, ram_rdata;

  logic [BASE_W-1:0]       base;
  logic [OFF_W-1:0]        beat, low_beat, crit_in;
  logic [LINE_BEATS-1:0]   beat_mask;
  logic                    xbar_fire, ev_last, retire;

  assign base      = addr_q[ADDR_W-1:OFF_W];
  assign beat      = cnt_q[OFF_W-1:0];
  assign crit_in   = mpc_isu_rc_set_way_offset[OFF_W-1:0];
  assign beat_mask = LINE_BEATS'(1) << beat;
  assign ev_last   = (dirty_q & ~beat_mask) == '0;
  assign xbar_fire = xbar_vld_q & mpc_rc_xbar_enable;

  always_comb begin
    low_beat = '0;
    for (int b = LINE_BEATS - 1; b >= 0; b--) begin
      if (dirty_q[b]) low_beat = OFF_W'(b);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dirty_d    = dirty_q;
    addr_d     = addr_q;
    ch_d       = ch_q;
    rob_d      = rob_q;
    wbid_d     = wbid_q;
    xbar_vld_d = xbar_vld_q;
    xbar_dat_d = xbar_dat_q;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_be     = '0;
    ram_addr   = addr_q;
    ram_wdata  = '0;
    retire     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mpc_isu_rc_valid) begin
          addr_d  = mpc_isu_rc_set_way_offset;
          ch_d    = mpc_isu_rc_channel_id;
          rob_d   = mpc_isu_rc_xbar_rob_num;
          wbid_d  = mpc_isu_rc_wbuffer_id;
          dirty_d = mpc_isu_rc_dirty;
          cnt_d   = '0;
          case (mpc_isu_rc_op_code)
            OP_RD: begin
              ram_cs     = 1'b1;
              ram_addr   = mpc_isu_rc_set_way_offset;
              xbar_vld_d = 1'b1;
              state_d    = S_RD_RTN;
            end
            OP_LF_RD: begin
              xbar_vld_d = 1'b1;
              xbar_dat_d = mpc_isu_rc_linefill_data[crit_in*DATA_W +: DATA_W];
              state_d    = S_LF;
            end
            OP_WR:    state_d = S_WB_REQ;
            OP_EVICT: state_d = S_EV_RD;
            // Unknown ops reuse the empty-eviction path: a bare one-cycle retire.
            default: begin
              dirty_d = '0;
              state_d = S_EV_RD;
            end
          endcase
        end
      end
      S_LF: begin
        if (xbar_fire) xbar_vld_d = 1'b0;
        if (cnt_q <= LAST_CNT) begin
          // Dirty beats hold newer data than the fill, but the critical beat always lands.
          if (!dirty_q[beat] || beat == addr_q[OFF_W-1:0]) begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_be    = '1;
            ram_addr  = {base, beat};
            ram_wdata = mpc_isu_rc_linefill_data[beat*DATA_W +: DATA_W];
          end
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_q >= LAST_CNT && (!xbar_vld_q || xbar_fire)) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_RTN: begin
        if (xbar_fire) begin
          xbar_vld_d = 1'b0;
          retire     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WB_REQ: begin
        if (mpc_rc_wbuf_req_enable) state_d = S_WB_RTN;
      end
      S_WB_RTN: begin
        if (mpc_rc_wbuf_rtn_valid) begin
          ram_cs    = 1'b1;
          ram_we    = 1'b1;
          ram_be    = mpc_rc_wbuf_rtn_be;
          ram_wdata = mpc_rc_wbuf_rtn_data;
          retire    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EV_RD: begin
        if (dirty_q == '0) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ram_cs   = 1'b1;
          ram_addr = {base, low_beat};
          cnt_d    = {1'b0, low_beat};
          state_d  = S_EV_SEND;
        end
      end
      S_EV_SEND: begin
        if (mpc_rc_subm_enable) begin
          dirty_d = dirty_q & ~beat_mask;
          if (ev_last) begin
            retire  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_EV_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dirty_q    <= '0;
      addr_q     <= '0;
      ch_q       <= '0;
      rob_q      <= '0;
      wbid_q     <= '0;
      xbar_vld_q <= 1'b0;
      xbar_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dirty_q    <= dirty_d;
      addr_q     <= addr_d;
      ch_q       <= ch_d;
      rob_q      <= rob_d;
      wbid_q     <= wbid_d;
      xbar_vld_q <= xbar_vld_d;
      xbar_dat_q <= xbar_dat_d;
    end
  end

  mpc_sram_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .cs_i    (ram_cs),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign mpc_isu_rc_enable          = retire;
  assign mpc_rc_xbar_valid          = xbar_vld_q;
  assign mpc_rc_xbar_channel_id     = ch_q;
  assign mpc_rc_xbar_rob_num        = rob_q;
  assign mpc_rc_xbar_data           = (state_q == S_RD_RTN) ? ram_rdata : xbar_dat_q;
  assign mpc_rc_subm_valid          = (state_q == S_EV_SEND);
  assign mpc_rc_subm_data           = ram_rdata;
  assign mpc_rc_subm_set_way_offset = {base, beat};
  assign mpc_rc_subm_last           = (state_q == S_EV_SEND) && ev_last;
  assign mpc_rc_wbuf_req_valid      = (state_q == S_WB_REQ);
  assign mpc_rc_wbuf_req_channel_id = ch_q;
  assign mpc_rc_wbuf_req_wbuffer_id = wbid_q;
  assign mpc_rc_wbuf_rtn_enable     = (state_q == S_WB_RTN);

endmodule

// File: tb/tb_mpc_sram_ctrl.sv
// Directed bench for mpc_sram_ctrl: stimulus pushes expected responses, a monitor pops and compares them.
// Enables are driven just after the clock edge; all sampling happens on the falling edge.
module tb_mpc_sram_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rc_valid, rc_enable;
  logic [2:0]   rc_op;
  logic [6:0]   rc_swo;
  logic [1:0]   rc_ch;
  logic [2:0]   rc_rob;
  logic [7:0]   rc_wbid;
  logic [1:0]   rc_dirty;
  logic [255:0] rc_lf;
  logic         xbar_valid, xbar_en;
  logic [1:0]   xbar_ch;
  logic [2:0]   xbar_rob;
  logic [127:0] xbar_data;
  logic         subm_valid, subm_en, subm_last;
  logic [127:0] subm_data;
  logic [6:0]   subm_swo;
  logic         wreq_valid, wreq_en;
  logic [1:0]   wreq_ch;
  logic [7:0]   wreq_wbid;
  logic         rtn_valid, rtn_en;
  logic [127:0] rtn_data;
  logic [15:0]  rtn_be;

  always #5 clk = ~clk;

  mpc_sram_ctrl dut (
    .clk                        (clk),
    .rst                        (rst),
    .mpc_isu_rc_valid           (rc_valid),
    .mpc_isu_rc_enable          (rc_enable),
    .mpc_isu_rc_op_code         (rc_op),
    .mpc_isu_rc_set_way_offset  (rc_swo),
    .mpc_isu_rc_channel_id      (rc_ch),
    .mpc_isu_rc_xbar_rob_num    (rc_rob),
    .mpc_isu_rc_wbuffer_id      (rc_wbid),
    .mpc_isu_rc_dirty           (rc_dirty),
    .mpc_isu_rc_linefill_data   (rc_lf),
    .mpc_rc_xbar_valid          (xbar_valid),
    .mpc_rc_xbar_enable         (xbar_en),
    .mpc_rc_xbar_channel_id     (xbar_ch),
    .mpc_rc_xbar_rob_num        (xbar_rob),
    .mpc_rc_xbar_data           (xbar_data),
    .mpc_rc_subm_valid          (subm_valid),
    .mpc_rc_subm_enable         (subm_en),
    .mpc_rc_subm_data           (subm_data),
    .mpc_rc_subm_set_way_offset (subm_swo),
    .mpc_rc_subm_last           (subm_last),
    .mpc_rc_wbuf_req_valid      (wreq_valid),
    .mpc_rc_wbuf_req_enable     (wreq_en),
    .mpc_rc_wbuf_req_channel_id (wreq_ch),
    .mpc_rc_wbuf_req_wbuffer_id (wreq_wbid),
    .mpc_rc_wbuf_rtn_valid      (rtn_valid),
    .mpc_rc_wbuf_rtn_enable     (rtn_en),
    .mpc_rc_wbuf_rtn_data       (rtn_data),
    .mpc_rc_wbuf_rtn_be         (rtn_be)
  );

  typedef struct packed { logic [1:0] ch; logic [2:0] rob; logic [127:0] dat; } xexp_t;
  typedef struct packed { logic [127:0] dat; logic [6:0] addr; logic last; } sexp_t;
  typedef struct packed { logic [1:0] ch; logic [7:0] wbid; } wexp_t;

  xexp_t xq[$];
  sexp_t sq[$];
  wexp_t wq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xbar_stall = 0;
  int stall_left = 0;
  bit subm_toggle = 1'b0;

  localparam logic [127:0] A5     = {16{8'hA5}};
  localparam logic [127:0] L0     = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] L1     = 128'hDEADBEEF00000001_CAFEF00D00000002;
  localparam logic [127:0] M0     = {16{8'h3C}};
  localparam logic [127:0] M1     = 128'h0F0F0F0F1E1E1E1E_2D2D2D2D3C3C3C3C;
  localparam logic [127:0] WR_EXP = 128'h0000000000000000_FFFFFFFFFFFFFFFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=valid required=no_pending_response", nm);
  endtask

  // Sink-side enable driver: xbar stalls a programmed number of cycles, subm optionally toggles.
  initial begin
    xbar_en = 1'b1;
    subm_en = 1'b1;
    wreq_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (xbar_valid) begin
        if (stall_left > 0) begin
          xbar_en = 1'b0;
          stall_left--;
        end else begin
          xbar_en = 1'b1;
        end
      end else begin
        xbar_en = 1'b1;
        stall_left = xbar_stall;
      end
      subm_en = subm_toggle ? ~subm_en : 1'b1;
    end
  end

  // Every valid cycle must already show the expected payload; pop only on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (xbar_valid) begin
          if (xq.size() == 0) unexpected("xbar_unexpected");
          else begin
            chk("xbar_data", xbar_data, xq[0].dat);
            chk("xbar_ch", xbar_ch, xq[0].ch);
            chk("xbar_rob", xbar_rob, xq[0].rob);
            if (xbar_en) void'(xq.pop_front());
          end
        end
        if (subm_valid) begin
          if (sq.size() == 0) unexpected("subm_unexpected");
          else begin
            chk("subm_data", subm_data, sq[0].dat);
            chk("subm_swo", subm_swo, sq[0].addr);
            chk("subm_last", subm_last, sq[0].last);
            if (subm_en) void'(sq.pop_front());
          end
        end
        if (wreq_valid) begin
          if (wq.size() == 0) unexpected("wreq_unexpected");
          else begin
            chk("wreq_ch", wreq_ch, wq[0].ch);
            chk("wreq_wbid", wreq_wbid, wq[0].wbid);
            if (wreq_en) void'(wq.pop_front());
          end
        end
      end
    end
  end

  task automatic cmd(input string nm, input logic [2:0] op, input logic [6:0] swo,
                     input logic [1:0] ch, input logic [2:0] rob, input logic [7:0] wbid,
                     input logic [1:0] dirty, input logic [255:0] lf, input int exp_lat);
    int t0;
    bit seen;
    @(negedge clk);
    rc_op = op; rc_swo = swo; rc_ch = ch; rc_rob = rob;
    rc_wbid = wbid; rc_dirty = dirty; rc_lf = lf;
    rc_valid = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rc_enable) seen = 1'b1;
    end
    rc_valid = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_retire actual=timeout required=retire_pulse", nm);
    end else begin
      if (exp_lat >= 0) chk({nm, "_latency"}, 256'(cyc - t0), 256'(exp_lat));
      @(negedge clk);
      chk({nm, "_pulse_width"}, rc_enable, 1'b0);
    end
  endtask

  task automatic push_x(input logic [1:0] ch, input logic [2:0] rob, input logic [127:0] d);
    xexp_t e;
    e.ch = ch; e.rob = rob; e.dat = d;
    xq.push_back(e);
  endtask

  task automatic push_s(input logic [127:0] d, input logic [6:0] a, input logic last);
    sexp_t e;
    e.dat = d; e.addr = a; e.last = last;
    sq.push_back(e);
  endtask

  task automatic push_w(input logic [1:0] ch, input logic [7:0] wbid);
    wexp_t e;
    e.ch = ch; e.wbid = wbid;
    wq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rc_valid = 1'b0; rc_op = '0; rc_swo = '0; rc_ch = '0; rc_rob = '0;
    rc_wbid = '0; rc_dirty = '0; rc_lf = '0;
    rtn_valid = 1'b0; rtn_data = '0; rtn_be = '0;
    repeat (3) @(negedge clk);
    chk("rst_xbar_valid", xbar_valid, 1'b0);
    chk("rst_xbar_data", xbar_data, 128'h0);
    chk("rst_xbar_ch_rob", {xbar_ch, xbar_rob}, 5'h0);
    chk("rst_subm_valid", subm_valid, 1'b0);
    chk("rst_subm_fields", {subm_data, subm_swo, subm_last}, 136'h0);
    chk("rst_wreq", {wreq_valid, wreq_ch, wreq_wbid}, 11'h0);
    chk("rst_rtn_enable", rtn_en, 1'b0);
    chk("rst_retire", rc_enable, 1'b0);
    rst = 1'b0;

    // Preload set 6 with 0xA5 and beat 0x10 with zero through the write path.
    rtn_valid = 1'b1; rtn_be = 16'hFFFF; rtn_data = A5;
    push_w(2'd1, 8'h11); cmd("wr_pre0", 3'b000, 7'h0C, 2'd1, 3'd0, 8'h11, 2'b00, '0, 2);
    push_w(2'd1, 8'h12); cmd("wr_pre1", 3'b000, 7'h0D, 2'd1, 3'd0, 8'h12, 2'b00, '0, 2);
    rtn_data = '0;
    push_w(2'd3, 8'h13); cmd("wr_pre2", 3'b000, 7'h10, 2'd3, 3'd0, 8'h13, 2'b00, '0, 2);

    // Clean linefill with critical beat 1, xbar always ready.
    xbar_stall = 0;
    push_x(2'd2, 3'd5, L1);
    cmd("lf_clean", 3'b010, 7'h0B, 2'd2, 3'd5, 8'h00, 2'b00, {L1, L0}, 2);
    push_x(2'd0, 3'd1, L0); cmd("rd_lf_b0", 3'b001, 7'h0A, 2'd0, 3'd1, 8'h00, 2'b00, '0, 1);
    push_x(2'd0, 3'd2, L1); cmd("rd_lf_b1", 3'b001, 7'h0B, 2'd0, 3'd2, 8'h00, 2'b00, '0, 1);

    // Beat 0 dirty: it keeps 0xA5, critical beat 1 is filled; xbar stalled 3 cycles.
    xbar_stall = 3;
    push_x(2'd3, 3'd6, M1);
    cmd("lf_dirty", 3'b010, 7'h0D, 2'd3, 3'd6, 8'h00, 2'b01, {M1, M0}, 4);
    xbar_stall = 0;
    push_x(2'd1, 3'd3, A5); cmd("rd_keep", 3'b001, 7'h0C, 2'd1, 3'd3, 8'h00, 2'b00, '0, 1);
    xbar_stall = 5;
    push_x(2'd2, 3'd4, M1); cmd("rd_stall", 3'b001, 7'h0D, 2'd2, 3'd4, 8'h00, 2'b00, '0, 6);
    xbar_stall = 0;

    // Byte-masked write: only the low 8 bytes take the new 0xFF data.
    rtn_data = {16{8'hFF}}; rtn_be = 16'h00FF;
    push_w(2'd2, 8'h3C); cmd("wr_be", 3'b000, 7'h10, 2'd2, 3'd0, 8'h3C, 2'b00, '0, 2);
    push_x(2'd0, 3'd0, WR_EXP); cmd("rd_wr", 3'b001, 7'h10, 2'd0, 3'd0, 8'h00, 2'b00, '0, 1);

    // Evictions with subm enable toggling, then the empty-mask and unknown-op cases.
    subm_toggle = 1'b1;
    push_s(A5, 7'h0C, 1'b0); push_s(M1, 7'h0D, 1'b1);
    cmd("ev_11", 3'b011, 7'h0C, 2'd0, 3'd0, 8'h00, 2'b11, '0, -1);
    push_s(M1, 7'h0D, 1'b1);
    cmd("ev_10", 3'b011, 7'h0C, 2'd0, 3'd0, 8'h00, 2'b10, '0, -1);
    subm_toggle = 1'b0;
    cmd("ev_00", 3'b011, 7'h0C, 2'd0, 3'd0, 8'h00, 2'b00, '0, 1);
    cmd("op_other", 3'b111, 7'h0C, 2'd0, 3'd0, 8'h00, 2'b11, '0, 1);

    // Reset while waiting on the write-buffer return.
    rtn_valid = 1'b0; rtn_data = '0; rtn_be = 16'hFFFF;
    push_w(2'd1, 8'h77);
    @(negedge clk);
    rc_op = 3'b000; rc_swo = 7'h0A; rc_ch = 2'd1; rc_wbid = 8'h77; rc_dirty = '0;
    rc_valid = 1'b1;
    for (int i = 0; i < 20 && !rtn_en; i++) @(negedge clk);
    chk("reach_wb_rtn", rtn_en, 1'b1);
    rst = 1'b1;
    rc_valid = 1'b0;
    #1;
    chk("rst_mid_valids", {xbar_valid, subm_valid, wreq_valid}, 3'b000);
    chk("rst_mid_enables", {rtn_en, rc_enable}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rtn_valid = 1'b1;
    push_x(2'd1, 3'd2, L0); cmd("rd_after_rst", 3'b001, 7'h0A, 2'd1, 3'd2, 8'h00, 2'b00, '0, 1);

    repeat (3) @(negedge clk);
    chk("xbar_queue_drained", 256'(xq.size()), 256'(0));
    chk("subm_queue_drained", 256'(sq.size()), 256'(0));
    chk("wreq_queue_drained", 256'(wq.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
